// File: rtl/pio_snoop_pkg.sv
// Shared definitions for the PIO snoop/inject paths: FIFO word layout,
// TLP header field offsets and the TX inject state encoding.
package pio_snoop_pkg;

   localparam int DATA_LSB  = 0;
   localparam int DATA_W    = 64;
   localparam int LO_EN_BIT = 64;
   localparam int HI_EN_BIT = 65;
   localparam int SOT_BIT   = 68;

   localparam int FMT_LSB  = 29;
   localparam int TYPE_LSB = 24;
   localparam int LEN_LSB  = 0;
   localparam int LEN_W    = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DROP
   } tx_state_t;

   // A zero length field with a payload-bearing fmt means the 1024-dword maximum.
   function automatic logic [10:0] payload_dwords(input logic [31:0] dw0);
      logic [LEN_W-1:0] len;
      len = dw0[LEN_LSB +: LEN_W];
      if (!dw0[FMT_LSB+1]) return 11'd0;
      if (len == '0) return 11'd1024;
      return {1'b0, len};
   endfunction

   function automatic logic [10:0] total_dwords(input logic [31:0] dw0);
      return (dw0[FMT_LSB] ? 11'd4 : 11'd3) + payload_dwords(dw0);
   endfunction

endpackage

// File: rtl/pio_tx_skid.sv
// AXI4-Stream output register: a beat holds until accepted, and a new beat
// may load in the same cycle the current one is taken.
module pio_tx_skid (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] data,
   input  logic [7:0]  keep,
   input  logic        last,
   input  logic [3:0]  user,
   output logic        ready,
   input  logic        tready,
   output logic [63:0] tdata,
   output logic [7:0]  tkeep,
   output logic        tlast,
   output logic [3:0]  tuser,
   output logic        tvalid
);

   assign ready = !tvalid || tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tvalid <= 1'b0;
         tdata  <= '0;
         tkeep  <= '0;
         tlast  <= 1'b0;
         tuser  <= '0;
      end else if (load) begin
         tvalid <= 1'b1;
         tdata  <= data;
         tkeep  <= keep;
         tlast  <= last;
         tuser  <= user;
      end else if (tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/pio_tx_inject.sv
// Replays framed TLP words from the receive FIFO onto the PCIe AXIS TX port.
// Define PIO_TX_STATS_EN to add the tlp_count/err_count statistics ports.
module pio_tx_inject #(
   parameter int MAX_PAYLOAD_DW = 256
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic [71:0] dout,
   input  logic        empty,
   output logic        rd_en,
   output logic [63:0] s_axis_tx_tdata,
   output logic [7:0]  s_axis_tx_tkeep,
   output logic        s_axis_tx_tlast,
   output logic        s_axis_tx_tvalid,
   input  logic        s_axis_tx_tready,
   output logic [3:0]  s_axis_tx_tuser
`ifdef PIO_TX_STATS_EN
   ,
   output logic [31:0] tlp_count,
   output logic [15:0] err_count
`endif
);

   import pio_snoop_pkg::*;

   localparam logic [11:0] MAX_PDW = 12'(MAX_PAYLOAD_DW);

   tx_state_t   state, next_state;
   logic        run;
   logic [63:0] stage_data;
   logic [9:0]  stage_left;
   logic        stage_odd;
   logic        stage_last;
   logic        is_marker, is_data, avail;
   logic [10:0] hdr_pdw, hdr_tdw;
   logic [9:0]  hdr_words;
   logic        oversize;
   logic        skid_ready;
   logic        load, load_last, load_dsc;
   logic [7:0]  load_keep;
   logic        take_hdr, take_next;
   logic        unused_bits;

   assign unused_bits = &{1'b0, dout[71:69], dout[67:66]};

   // run holds the FIFO untouched for the first cycle after reset release.
   assign avail      = run && !empty;
   assign is_marker  = dout[SOT_BIT];
   assign is_data    = !dout[SOT_BIT] && (dout[HI_EN_BIT] || dout[LO_EN_BIT]);
   assign hdr_pdw    = payload_dwords(dout[31:0]);
   assign hdr_tdw    = total_dwords(dout[31:0]);
   assign hdr_words  = 10'((hdr_tdw + 11'd1) >> 1);
   assign oversize   = {1'b0, hdr_pdw} > MAX_PDW;
   assign stage_last = (stage_left == 10'd1);

   always_comb begin
      next_state = state;
      rd_en      = 1'b0;
      load       = 1'b0;
      load_last  = 1'b0;
      load_keep  = 8'hFF;
      load_dsc   = 1'b0;
      take_hdr   = 1'b0;
      take_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            rd_en = avail;
            if (avail && is_marker) next_state = ST_HDR;
         end
         ST_HDR: begin
            rd_en = avail;
            if (avail) begin
               if (is_data) begin
                  if (oversize) begin
                     next_state = ST_DROP;
                  end else begin
                     take_hdr   = 1'b1;
                     next_state = ST_DATA;
                  end
               end else if (!is_marker) begin
                  next_state = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            // The final word goes out without waiting on a lookahead word.
            if (stage_last) begin
               if (skid_ready) begin
                  load       = 1'b1;
                  load_last  = 1'b1;
                  load_keep  = stage_odd ? 8'h0F : 8'hFF;
                  next_state = ST_IDLE;
               end
            end else begin
               rd_en = avail && skid_ready;
               if (rd_en) begin
                  load = 1'b1;
                  if (is_data) begin
                     take_next = 1'b1;
                  end else begin
                     load_last  = 1'b1;
                     load_dsc   = 1'b1;
                     next_state = is_marker ? ST_HDR : ST_IDLE;
                  end
               end
            end
         end
         ST_DROP: begin
            rd_en = avail;
            if (avail && is_marker) next_state = ST_HDR;
            else if (avail && !is_data) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         run        <= 1'b0;
         stage_data <= '0;
         stage_left <= '0;
         stage_odd  <= 1'b0;
      end else begin
         run   <= 1'b1;
         state <= next_state;
         if (take_hdr) begin
            stage_data <= dout[DATA_LSB +: DATA_W];
            stage_left <= hdr_words;
            stage_odd  <= hdr_tdw[0];
         end else if (take_next) begin
            stage_data <= dout[DATA_LSB +: DATA_W];
            stage_left <= stage_left - 10'd1;
         end
      end
   end

   pio_tx_skid u_skid (
      .clk    (clk),
      .rst    (sys_rst),
      .load   (load),
      .data   (stage_data),
      .keep   (load_keep),
      .last   (load_last),
      .user   ({load_dsc, 3'b000}),
      .ready  (skid_ready),
      .tready (s_axis_tx_tready),
      .tdata  (s_axis_tx_tdata),
      .tkeep  (s_axis_tx_tkeep),
      .tlast  (s_axis_tx_tlast),
      .tuser  (s_axis_tx_tuser),
      .tvalid (s_axis_tx_tvalid)
   );

`ifdef PIO_TX_STATS_EN
   logic stray_run, tlp_inc, err_inc;

   // A run of stray data words in IDLE counts as a single error.
   always_comb begin
      tlp_inc = (state == ST_DATA) && stage_last && skid_ready;
      err_inc = 1'b0;
      case (state)
         ST_IDLE: err_inc = avail && is_data && !stray_run;
         ST_HDR:  err_inc = avail && (!is_data || oversize);
         ST_DATA: err_inc = load && load_dsc;
         default: err_inc = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         stray_run <= 1'b0;
         tlp_count <= '0;
         err_count <= '0;
      end else begin
         if (state == ST_IDLE && avail) stray_run <= is_data;
         if (tlp_inc && tlp_count != '1) tlp_count <= tlp_count + 32'd1;
         if (err_inc && err_count != '1) err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule
